uart_rx: RTL and testbench

Serial receiver for the UART path, 8N1 by default. Consumes the 16x-oversampling `baud_tick` strobe from the baud rate generator and the asynchronous `rx` line. Detects and validates start bits, samples each bit at its centre and checks the stop bit. Presents each received byte as a one-cycle `data_valid` pulse, or a one-cycle `frame_error` pulse if the stop bit is bad.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the frame constants
// that the baud rate generator, receiver and transmitter must agree on.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous level input. The chain resets
// to 1 so that an idle-high serial line never looks like a start bit while
// the chain is filling after reset.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the raw input through the chain; the oldest bit is the safe output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default. Works from the 16x oversampling baud tick,
// validates the start bit at its centre, samples every data bit at its
// centre (LSB first) and checks the stop bit. A good frame gives a one-clock
// data_valid pulse with data_out updated on the same edge; a low stop bit
// gives a one-clock frame_error pulse and parks the receiver in BREAK until
// the line returns high, so a held-low line cannot produce repeated frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  // Start bit is confirmed half a bit after the edge; every later sample is
  // a full bit period after the previous one, landing in the bit centres.
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_state_t          r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_frame_error;
  logic                 r_busy;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // Receive FSM with counters, shift register and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // Result strobes last exactly one clock.
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;

      if (baud_tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state    <= START;
              r_tick_cnt <= '0;
              r_busy     <= 1'b1;
            end
          end

          START: begin
            if (r_tick_cnt == HALF_LAST) begin
              r_tick_cnt <= '0;
              if (!w_rx_s) begin
                r_state   <= DATA;
                r_bit_cnt <= '0;
              end else begin
                // Line went back high before mid start bit: a glitch.
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == BIT_LAST) begin
                r_state   <= STOP;
                r_bit_cnt <= '0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end

          STOP: begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              if (w_rx_s) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
                r_state      <= IDLE;
                r_busy       <= 1'b0;
              end else begin
                // data_out keeps the last good byte.
                r_frame_error <= 1'b1;
                r_state       <= BREAK;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end

          BREAK: begin
            if (w_rx_s) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx. Frames are described at the
// line level (start, LSB-first data, stop, each a number of clocks); the
// reference model is simply "a frame with a high stop bit delivers its byte,
// a frame with a low stop bit delivers a frame error and keeps the old byte".
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Observed results (filled by the monitor)
  byte unsigned dv_q[$];
  int           fe_count  = 0;
  logic         busy_seen = 1'b0;

  // Reference model state
  byte unsigned exp_q[$];
  int           exp_fe   = 0;
  logic [7:0]   exp_data = 8'h00;

  uart_rx #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // One baud tick every 4 clocks
  initial begin : tick_gen
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      n++;
      baud_tick = (n % 4 == 0);
    end
  end

  // Record output pulses shortly after each active edge
  always @(posedge clock) begin
    #1;
    if (data_valid) dv_q.push_back(data_out);
    if (frame_error) fe_count++;
    if (busy) busy_seen = 1'b1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive one frame; skew alternately lengthens/shortens successive bits.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int skew);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (BIT_CLKS + ((i % 2 == 0) ? skew : -skew)) @(negedge clock);
    end
    $display("frame sent: byte=0x%02h stop=%0b skew=%0d", b, stop_bit, skew);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(b);
      exp_data = b;
    end else begin
      exp_fe++;
    end
  endtask

  task automatic check_stream(input string tag);
    chk($sformatf("%s_dv_count", tag), dv_q.size(), exp_q.size());
    chk($sformatf("%s_fe_count", tag), fe_count, exp_fe);
    chk($sformatf("%s_data_out", tag), data_out, exp_data);
    while (dv_q.size() > 0 && exp_q.size() > 0)
      chk($sformatf("%s_byte", tag), dv_q.pop_front(), exp_q.pop_front());
    dv_q.delete();
    exp_q.delete();
  endtask

  initial begin : stimulus
    logic       saw_high;
    logic       fell;
    int         skew;
    logic [7:0] b;
    logic       stop_bit;

    // Reset state
    idle_clocks(3);
    chk("reset_busy", busy, 0);
    chk("reset_data_valid", data_valid, 0);
    chk("reset_frame_error", frame_error, 0);
    chk("reset_data_out", data_out, 0);
    reset = 1'b0;

    // Idle line
    busy_seen = 1'b0;
    idle_clocks(2000);
    chk("idle_busy_seen", busy_seen, 0);
    check_stream("idle");

    // Two good frames back to back
    send_frame(8'h55, 1'b1, 0);
    model_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1, 0);
    model_frame(8'hA3, 1'b1);
    idle_clocks(20);
    check_stream("good");

    // 20-clock glitch: busy rises then falls within 40 clocks, no output
    saw_high = 1'b0;
    fell     = 1'b0;
    rx = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c == 20) rx = 1'b1;
      if (busy) saw_high = 1'b1;
      else if (saw_high) fell = 1'b1;
    end
    chk("glitch_busy_rose", saw_high, 1);
    chk("glitch_busy_fell", fell, 1);
    idle_clocks(100);
    check_stream("glitch");

    // Low stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0, 0);
    model_frame(8'h3C, 1'b0);
    idle_clocks(500);
    check_stream("badstop");
    chk("badstop_busy", busy, 1);
    chk("badstop_state", 32'(dut.r_state), 32'(BREAK));
    rx = 1'b1;
    idle_clocks(64);
    chk("break_release_busy", busy, 0);
    send_frame(8'h81, 1'b1, 0);
    model_frame(8'h81, 1'b1);
    idle_clocks(20);
    check_stream("after_break");

    // Reset in the middle of data bit 4 of 0xFF
    rx = 1'b0;
    idle_clocks(BIT_CLKS);
    rx = 1'b1;
    idle_clocks(4 * BIT_CLKS + BIT_CLKS / 2);
    chk("midframe_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", busy, 0);
    chk("async_reset_data_out", data_out, 0);
    chk("async_reset_data_valid", data_valid, 0);
    chk("async_reset_frame_error", frame_error, 0);
    exp_data = 8'h00;
    idle_clocks(3);
    reset = 1'b0;
    idle_clocks(BIT_CLKS / 2 + 4 * BIT_CLKS);
    send_frame(8'h0F, 1'b1, 0);
    model_frame(8'h0F, 1'b1);
    idle_clocks(20);
    check_stream("after_reset");

    // Bit-length skew of 3 clocks
    skew = ($urandom_range(0, 1) == 1) ? 3 : -3;
    send_frame(8'h96, 1'b1, skew);
    model_frame(8'h96, 1'b1);
    idle_clocks(20);
    check_stream("skew");

    // Random frames, random gaps, occasional bad stop bit and skew
    for (int f = 0; f < 10; f++) begin
      b        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       skew = -3;
        1:       skew = 0;
        default: skew = 3;
      endcase
      send_frame(b, stop_bit, skew);
      model_frame(b, stop_bit);
      rx = 1'b1;
      idle_clocks($urandom_range(12, 80));
      check_stream($sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
